// File: rtl/hwpe_tcdm_port_sequencer.sv
// Splits one wide TCDM transaction into NrPorts narrow port requests and
// reassembles the narrow responses into a single wide response beat.

module hwpe_tcdm_port_lane #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_i,
    input  logic                 track_i,
    input  logic                 clear_i,
    input  logic                 q_ready_i,
    input  logic                 p_valid_i,
    input  logic [DataWidth-1:0] p_data_i,
    output logic                 q_valid_o,
    output logic                 issued_d_o,
    output logic                 done_d_o,
    output logic [DataWidth-1:0] buf_o
);

    logic                 issued_q, issued_d;
    logic                 done_q, done_d;
    logic [DataWidth-1:0] buf_q, buf_d;
    logic                 grant;
    logic                 accept;

    assign q_valid_o = issue_i & ~issued_q;
    assign grant     = q_valid_o & q_ready_i;
    // A response may land in the same cycle as its own grant.
    assign accept    = track_i & p_valid_i & (issued_q | grant) & ~done_q;

    always_comb begin
        issued_d = issued_q;
        done_d   = done_q;
        buf_d    = buf_q;
        if (clear_i) begin
            issued_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            if (grant) begin
                issued_d = 1'b1;
            end
            if (accept) begin
                done_d = 1'b1;
                buf_d  = p_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            issued_q <= 1'b0;
            done_q   <= 1'b0;
            buf_q    <= '0;
        end else begin
            issued_q <= issued_d;
            done_q   <= done_d;
            buf_q    <= buf_d;
        end
    end

    assign issued_d_o = issued_d;
    assign done_d_o   = done_d;
    assign buf_o      = buf_q;

endmodule

module hwpe_tcdm_port_sequencer #(
    parameter int unsigned NrPorts       = 4,
    parameter int unsigned PortDataWidth = 64,
    parameter int unsigned AddrWidth     = 32,
    localparam int unsigned W            = NrPorts * PortDataWidth,
    localparam int unsigned B            = W / 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wide_req_i,
    output logic                         wide_gnt_o,
    input  logic [AddrWidth-1:0]         wide_addr_i,
    input  logic                         wide_wen_i,
    input  logic [B-1:0]                 wide_be_i,
    input  logic [W-1:0]                 wide_data_i,
    output logic                         wide_r_valid_o,
    output logic [W-1:0]                 wide_r_data_o,
    output logic [NrPorts-1:0]           narrow_q_valid_o,
    input  logic [NrPorts-1:0]           narrow_q_ready_i,
    output logic [NrPorts*AddrWidth-1:0] narrow_addr_o,
    output logic [NrPorts-1:0]           narrow_write_o,
    output logic [B-1:0]                 narrow_strb_o,
    output logic [W-1:0]                 narrow_data_o,
    input  logic [NrPorts-1:0]           narrow_p_valid_i,
    input  logic [W-1:0]                 narrow_p_data_i,
    output logic                         busy_o
);

    localparam int unsigned PortBytes = PortDataWidth / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   wen_q, wen_d;
    logic [B-1:0]           be_q, be_d;
    logic [W-1:0]           data_q, data_d;

    logic [NrPorts-1:0]     issued_nxt;
    logic [NrPorts-1:0]     done_nxt;
    logic                   in_issue;
    logic                   in_track;
    logic                   in_resp;

    assign in_issue = (state_q == ISSUE);
    assign in_track = (state_q == ISSUE) || (state_q == WAIT);
    assign in_resp  = (state_q == RESP);

    for (genvar i = 0; i < NrPorts; i++) begin : g_port
        hwpe_tcdm_port_lane #(
            .DataWidth (PortDataWidth)
        ) i_lane (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .issue_i    (in_issue),
            .track_i    (in_track),
            .clear_i    (in_resp),
            .q_ready_i  (narrow_q_ready_i[i]),
            .p_valid_i  (narrow_p_valid_i[i]),
            .p_data_i   (narrow_p_data_i[i*PortDataWidth +: PortDataWidth]),
            .q_valid_o  (narrow_q_valid_o[i]),
            .issued_d_o (issued_nxt[i]),
            .done_d_o   (done_nxt[i]),
            .buf_o      (wide_r_data_o[i*PortDataWidth +: PortDataWidth])
        );

        // Address wraps naturally modulo 2^AddrWidth; forced to 0 while idle.
        assign narrow_addr_o[i*AddrWidth +: AddrWidth] =
            busy_o ? addr_q + AddrWidth'(i * PortBytes) : '0;
        assign narrow_write_o[i] = busy_o & ~wen_q;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        be_d    = be_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (wide_req_i) begin
                    addr_d  = wide_addr_i;
                    wen_d   = wide_wen_i;
                    be_d    = wide_be_i;
                    data_d  = wide_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (&done_nxt) begin
                    state_d = RESP;
                end else if (&issued_nxt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (&done_nxt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            be_q    <= be_d;
            data_q  <= data_d;
        end
    end

    assign wide_gnt_o     = (state_q == IDLE);
    assign wide_r_valid_o = in_resp;
    assign busy_o         = (state_q != IDLE);
    assign narrow_strb_o  = be_q;
    assign narrow_data_o  = data_q;

endmodule

// File: tb/tb_hwpe_tcdm_port_sequencer.sv
// Randomized and directed checks of the port sequencer against a
// transaction-level model (grants/responses tracked per wide transaction).

module tb_hwpe_tcdm_port_sequencer;

    localparam int NP  = 4;
    localparam int PDW = 64;
    localparam int AW  = 32;
    localparam int W   = NP * PDW;
    localparam int B   = W / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              wide_req_i;
    logic              wide_gnt_o;
    logic [AW-1:0]     wide_addr_i;
    logic              wide_wen_i;
    logic [B-1:0]      wide_be_i;
    logic [W-1:0]      wide_data_i;
    logic              wide_r_valid_o;
    logic [W-1:0]      wide_r_data_o;
    logic [NP-1:0]     narrow_q_valid_o;
    logic [NP-1:0]     narrow_q_ready_i;
    logic [NP*AW-1:0]  narrow_addr_o;
    logic [NP-1:0]     narrow_write_o;
    logic [B-1:0]      narrow_strb_o;
    logic [W-1:0]      narrow_data_o;
    logic [NP-1:0]     narrow_p_valid_i;
    logic [W-1:0]      narrow_p_data_i;
    logic              busy_o;

    hwpe_tcdm_port_sequencer #(
        .NrPorts       (NP),
        .PortDataWidth (PDW),
        .AddrWidth     (AW)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .wide_req_i       (wide_req_i),
        .wide_gnt_o       (wide_gnt_o),
        .wide_addr_i      (wide_addr_i),
        .wide_wen_i       (wide_wen_i),
        .wide_be_i        (wide_be_i),
        .wide_data_i      (wide_data_i),
        .wide_r_valid_o   (wide_r_valid_o),
        .wide_r_data_o    (wide_r_data_o),
        .narrow_q_valid_o (narrow_q_valid_o),
        .narrow_q_ready_i (narrow_q_ready_i),
        .narrow_addr_o    (narrow_addr_o),
        .narrow_write_o   (narrow_write_o),
        .narrow_strb_o    (narrow_strb_o),
        .narrow_data_o    (narrow_data_o),
        .narrow_p_valid_i (narrow_p_valid_i),
        .narrow_p_data_i  (narrow_p_data_i),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // transaction-level model state
    bit            active;     // a wide transaction has been accepted
    bit            resp_now;   // all responses in; wide response due this cycle
    logic [NP-1:0] granted;
    logic [NP-1:0] responded;
    logic [AW-1:0] m_addr;
    bit            m_wen;
    logic [B-1:0]  m_be;
    logic [W-1:0]  m_data;
    logic [W-1:0]  exp_buf;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_rvalid = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        logic [NP-1:0] exp_qv;
        exp_qv = (active && !resp_now) ? ~granted : '0;
        chk("gnt", wide_gnt_o, !active);
        chk("busy", busy_o, active);
        chk("rvalid", wide_r_valid_o, resp_now);
        chk("gnt_rvalid_excl", wide_gnt_o & wide_r_valid_o, 1'b0);
        chk("qvalid", narrow_q_valid_o, exp_qv);
        chk("rdata", wide_r_data_o, exp_buf);
        if (wide_r_valid_o) n_rvalid++;
        if (active) begin
            for (int i = 0; i < NP; i++) begin
                logic [AW-1:0] ea;
                ea = m_addr + AW'(i * (PDW / 8));
                chk($sformatf("addr%0d", i), narrow_addr_o[i*AW +: AW], ea);
            end
            chk("write", narrow_write_o, {NP{!m_wen}});
            chk("strb", narrow_strb_o, m_be);
            chk("wdata", narrow_data_o, m_data);
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic step(input bit req, input logic [AW-1:0] a, input bit wen,
                        input logic [B-1:0] be, input logic [W-1:0] d,
                        input logic [NP-1:0] rdy, input logic [NP-1:0] rsp);
        logic [NP-1:0] gn, legal;
        logic [W-1:0]  pd;
        @(negedge clk_i);
        check_outputs();
        pd               = rand_wide();
        wide_req_i       = req;
        wide_addr_i      = a;
        wide_wen_i       = wen;
        wide_be_i        = be;
        wide_data_i      = d;
        narrow_q_ready_i = rdy;
        narrow_p_valid_i = rsp;
        narrow_p_data_i  = pd;
        gn    = (active && !resp_now) ? (~granted & rdy) : '0;
        legal = (active && !resp_now) ? ((granted | gn) & ~responded & rsp) : '0;
        @(posedge clk_i);
        if (!active) begin
            if (req) begin
                active    = 1'b1;
                granted   = '0;
                responded = '0;
                m_addr    = a;
                m_wen     = wen;
                m_be      = be;
                m_data    = d;
            end
        end else if (resp_now) begin
            active   = 1'b0;
            resp_now = 1'b0;
        end else begin
            granted = granted | gn;
            for (int i = 0; i < NP; i++)
                if (legal[i]) exp_buf[i*PDW +: PDW] = pd[i*PDW +: PDW];
            responded = responded | legal;
            if (&responded) resp_now = 1'b1;
        end
    endtask

    task automatic idle(input logic [NP-1:0] rdy, input logic [NP-1:0] rsp);
        step(1'b0, '0, 1'b0, '0, '0, rdy, rsp);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i            = 1'b1;
        wide_req_i       = 1'b0;
        narrow_q_ready_i = '0;
        narrow_p_valid_i = '0;
        active    = 1'b0;
        resp_now  = 1'b0;
        granted   = '0;
        responded = '0;
        exp_buf   = '0;
        #1;
        check_outputs();
        chk("rst_addr", narrow_addr_o, '0);
        chk("rst_wdata", narrow_data_o, '0);
        chk("rst_strb", narrow_strb_o, '0);
        chk("rst_qvalid", narrow_q_valid_o, '0);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        int rv0;
        rst_i = 1'b1;
        wide_req_i = 0; wide_addr_i = 0; wide_wen_i = 0; wide_be_i = 0; wide_data_i = 0;
        narrow_q_ready_i = 0; narrow_p_valid_i = 0; narrow_p_data_i = 0;
        do_reset();

        // read at 0x1000, minimum latency
        rv0 = n_rvalid;
        step(1'b1, 32'h0000_1000, 1'b1, '1, rand_wide(), '0, '0);
        idle(4'hF, 4'h0);
        idle(4'h0, 4'hF);
        idle(4'h0, 4'h0);           // wide_r_valid_o expected here (cycle 3)
        idle(4'h0, 4'h0);
        chk("lat_pulses", 32'(n_rvalid - rv0), 32'd1);

        // staggered readiness
        rv0 = n_rvalid;
        step(1'b1, 32'h0000_2000, 1'b1, rand_wide(), rand_wide(), '0, '0);
        idle(4'b1000, 4'h0);
        idle(4'b0001, 4'h0);
        idle(4'b0000, 4'b1001);
        idle(4'b0110, 4'h0);
        idle(4'h0, 4'b0110);
        idle(4'h0, 4'h0);
        idle(4'h0, 4'h0);
        chk("stagger_pulses", 32'(n_rvalid - rv0), 32'd1);

        // full write with 0xA5 pattern
        rv0 = n_rvalid;
        step(1'b1, 32'h0000_3000, 1'b0, '1, {(W/8){8'hA5}}, '0, '0);
        idle(4'hF, 4'b0000);
        idle(4'h0, 4'b0011);
        idle(4'h0, 4'b1100);
        idle(4'h0, 4'h0);
        idle(4'h0, 4'h0);
        chk("write_pulses", 32'(n_rvalid - rv0), 32'd1);

        // address wrap
        step(1'b1, 32'hFFFF_FFF0, 1'b1, '1, rand_wide(), '0, '0);
        idle(4'hF, 4'h0);
        idle(4'h0, 4'hF);
        idle(4'h0, 4'h0);

        // spurious in IDLE, duplicate in WAIT
        idle(4'h0, 4'b0100);
        step(1'b1, 32'h0000_4000, 1'b1, '1, rand_wide(), '0, 4'b0100);
        idle(4'hF, 4'h0);
        idle(4'h0, 4'b0010);
        idle(4'h0, 4'b0010);
        idle(4'h0, 4'b1101);
        idle(4'h0, 4'h0);

        // reset in WAIT with 2 of 4 responses, late responses afterwards
        rv0 = n_rvalid;
        step(1'b1, 32'h0000_5000, 1'b1, '1, rand_wide(), '0, '0);
        idle(4'hF, 4'h0);
        idle(4'h0, 4'b0011);
        idle(4'h0, 4'h0);
        do_reset();
        chk("rst_no_pulse", 32'(n_rvalid - rv0), 32'd0);
        step(1'b1, 32'h0000_6000, 1'b1, '1, rand_wide(), '0, 4'b1100);
        idle(4'hF, 4'h0);
        idle(4'h0, 4'hF);
        idle(4'h0, 4'h0);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | AW'($urandom_range(0, 31))) : AW'($urandom);
            step($urandom_range(0, 2) == 0, a, 1'($urandom), B'($urandom), rand_wide(),
                 NP'($urandom), NP'($urandom));
        end
        for (int n = 0; n < 8; n++) idle(4'hF, 4'hF);
        idle(4'h0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hwpe_tcdm_port_sequencer.md
HWPE_TCDM_PORT_SEQUENCER -- requirements
Module: hwpe_tcdm_port_sequencer

Interface
REQ-001 SHALL have parameter NrPorts, default 4, number of narrow TCDM ports.
REQ-002 SHALL have parameter PortDataWidth, default 64, narrow port data width in bits.
REQ-003 SHALL have parameter AddrWidth, default 32, byte address width; W = NrPorts*PortDataWidth and B = W/8 are derived.
REQ-004 SHALL have port clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports wide_req_i in 1, wide_gnt_o out 1  wide-side request/grant.
REQ-007 SHALL have ports wide_addr_i in AddrWidth, wide_wen_i in 1 (1=read, 0=write), wide_be_i in B, wide_data_i in W.
REQ-008 SHALL have ports wide_r_valid_o out 1, wide_r_data_o out W  wide-side response.
REQ-009 SHALL have ports narrow_q_valid_o out NrPorts, narrow_q_ready_i in NrPorts  per-port request handshake.
REQ-010 SHALL have ports narrow_addr_o out NrPorts*AddrWidth, narrow_write_o out NrPorts, narrow_strb_o out B, narrow_data_o out W  per-port payload, port i in slice i.
REQ-011 SHALL have ports narrow_p_valid_i in NrPorts, narrow_p_data_i in W  per-port responses, port i in slice i.
REQ-012 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one wide transaction outstanding at most.
REQ-014 SHALL drive wide_gnt_o = 1 exactly when state is IDLE; wide_req_i & wide_gnt_o captures addr/wen/be/data into registers and moves to ISSUE next cycle.
REQ-015 SHALL in ISSUE assert narrow_q_valid_o[i] for every port whose issued bit is 0; payload comes only from registers and is stable until its handshake.
REQ-016 SHALL drive port i: addr = captured addr + i*(PortDataWidth/8) modulo 2^AddrWidth; write = ~wen; strb = be slice i; data = data slice i.
REQ-017 SHALL set issued[i] on narrow_q_valid_o[i] & narrow_q_ready_i[i]; ports grant independently, in any order, any cycle.
REQ-018 SHALL go ISSUE->WAIT in the cycle after all issued bits are 1 (including grants in the current cycle); all-granted on the first ISSUE cycle gives ISSUE for exactly one cycle.
REQ-019 SHALL capture narrow_p_data_i slice i into buffer and set done[i] when narrow_p_valid_i[i] is 1, issued[i] (or a same-cycle grant) is 1, and done[i] is 0, in ISSUE or WAIT.
REQ-020 SHALL ignore narrow_p_valid_i[i] when port i is not outstanding or already done, and in IDLE/RESP.
REQ-021 SHALL go to RESP in the cycle after all done bits are 1, from either ISSUE or WAIT.
REQ-022 SHALL in RESP assert wide_r_valid_o for exactly one cycle with wide_r_data_o = buffer (slice i from port i), then return to IDLE and clear issued/done.
REQ-023 SHALL treat writes identically (wait for all NrPorts responses, pulse wide_r_valid_o); wide_r_data_o contents for writes are don't-care.
REQ-024 SHALL hold wide_r_data_o at the last buffer value outside RESP.
REQ-025 SHALL yield minimum latency: accept at cycle 0, narrow request at 1, responses at 2, wide_r_valid_o at 3.
REQ-026 SHALL never assert wide_gnt_o and wide_r_valid_o in the same cycle.

Reset
REQ-027 SHALL on rst_i=1 immediately go to IDLE, clear issued, done, buffer and captured registers to 0; outputs wide_gnt_o=1, wide_r_valid_o=0, narrow_q_valid_o=0, busy_o=0, data/addr outputs 0.
REQ-028 SHALL on reset mid-transaction drop the transaction with no wide_r_valid_o; late narrow responses afterwards are ignored per REQ-020.

Verification
REQ-029 SHALL cover: read addr 0x1000, all ports ready, responses 1 cycle later -> narrow addrs 0x1000/08/10/18, wide_r_valid_o at cycle 3, data = {p3,p2,p1,p0}.
REQ-030 SHALL cover: ready staggered port3 cycle1, port0 cycle2, ports1-2 cycle4 -> each q_valid drops only after its own grant, payload stable, one wide_r_valid_o after the last response.
REQ-031 SHALL cover: write be=all-ones, data pattern 0xA5.. -> narrow_write_o=1111, strb slices 0xFF, wide_r_valid_o once after 4 responses.
REQ-032 SHALL cover: addr 0xFFFFFFF0 -> port addrs 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000, 0x00000008.
REQ-033 SHALL cover: spurious p_valid on port2 in IDLE and a duplicate on port1 in WAIT -> ignored, buffer unchanged.
REQ-034 SHALL cover: rst_i asserted in WAIT with 2 of 4 responses -> IDLE, busy_o=0, no wide_r_valid_o, new request accepted next cycle.
